// File: rtl/branch_ctrl.sv
// ============================================================================
//  Module   : branch_ctrl
//  Purpose  : Decode-stage branch sequencer: stalls on operand hazards,
//             resolves via the external comparator and issues a registered
//             PC redirect after the delay slot. Keeps saturating statistics.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             br_valid,
   input  logic [2:0]       br_type,
   input  logic [31:0]      br_target,
   input  logic             rs_busy,
   input  logic             rt_busy,
   input  logic             id_hold,
   input  logic             cmp_result,
   input  logic             cnt_clr,
   output logic [2:0]       cmp_op,
   output logic             br_stall,
   output logic             br_ack,
   output logic             redirect_valid,
   output logic [31:0]      redirect_pc,
   output logic             illegal_op,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] taken_cnt,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam logic [0:0]       c_IDLE = 1'b0;
   localparam logic [0:0]       c_WAIT = 1'b1;
   localparam logic [CNT_W-1:0] c_MAX  = {CNT_W{1'b1}};

   logic [0:0]       r_state;
   logic [0:0]       w_next_state;
   logic             w_need_busy;
   logic             w_resolve;
   logic             w_illegal;
   logic             w_taken;
   logic             w_stall_inc;
   logic             r_redirect_valid;
   logic [31:0]      r_redirect_pc;
   logic             r_illegal_op;
   logic [CNT_W-1:0] r_branch_cnt;
   logic [CNT_W-1:0] r_taken_cnt;
   logic [CNT_W-1:0] r_stall_cnt;

   // Only eq/ne compare two registers; the zero-compare forms need rs alone.
   assign w_need_busy = rs_busy | (rt_busy & (br_type <= 3'd1));
   assign w_resolve   = br_valid & ~w_need_busy & ~id_hold;
   assign w_illegal   = br_type[2] & br_type[1];
   assign w_taken     = w_resolve & ~w_illegal & cmp_result;
   assign w_stall_inc = br_valid & w_need_busy & ~id_hold;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_IDLE: begin
            if (br_valid & w_need_busy & ~id_hold) begin
               w_next_state = c_WAIT;
            end
         end
         c_WAIT: begin
            // A dropped br_valid while waiting means the branch was flushed.
            if (w_resolve | ~br_valid) begin
               w_next_state = c_IDLE;
            end
         end
         default: w_next_state = c_IDLE;
      endcase
   end

   always_comb begin
      cmp_op   = 3'd0;
      br_stall = 1'b0;
      br_ack   = 1'b0;
      if (br_valid) begin
         cmp_op   = br_type;
         br_stall = w_need_busy;
         br_ack   = w_resolve;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_redirect_valid <= 1'b0;
         r_redirect_pc    <= 32'd0;
         r_illegal_op     <= 1'b0;
      end else begin
         r_redirect_valid <= w_taken;
         if (w_taken) begin
            r_redirect_pc <= br_target;
         end
         if (w_resolve & w_illegal) begin
            r_illegal_op <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_branch_cnt <= '0;
         r_taken_cnt  <= '0;
         r_stall_cnt  <= '0;
      end else if (cnt_clr) begin
         r_branch_cnt <= '0;
         r_taken_cnt  <= '0;
         r_stall_cnt  <= '0;
      end else begin
         if (w_resolve && (r_branch_cnt != c_MAX)) begin
            r_branch_cnt <= r_branch_cnt + 1'b1;
         end
         if (w_taken && (r_taken_cnt != c_MAX)) begin
            r_taken_cnt <= r_taken_cnt + 1'b1;
         end
         if (w_stall_inc && (r_stall_cnt != c_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
         end
      end
   end

   assign redirect_valid = r_redirect_valid;
   assign redirect_pc    = r_redirect_pc;
   assign illegal_op     = r_illegal_op;
   assign branch_cnt     = r_branch_cnt;
   assign taken_cnt      = r_taken_cnt;
   assign stall_cnt      = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_branch_ctrl.sv
// ============================================================================
//  Module   : tb_branch_ctrl
//  Purpose  : Self-checking bench for branch_ctrl (16-bit and 2-bit counters).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        br_valid, rs_busy, rt_busy, id_hold, cmp_result, cnt_clr;
   logic [2:0]  br_type;
   logic [31:0] br_target;

   logic [2:0]  cmp_op, cmp_op_s;
   logic        br_stall, br_ack, redirect_valid, illegal_op;
   logic        br_stall_s, br_ack_s, redirect_valid_s, illegal_op_s;
   logic [31:0] redirect_pc, redirect_pc_s;
   logic [15:0] branch_cnt, taken_cnt, stall_cnt;
   logic [1:0]  branch_cnt_s, taken_cnt_s, stall_cnt_s;

   int checks = 0;
   int errors = 0;

   branch_ctrl #(.CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_type(br_type),
      .br_target(br_target), .rs_busy(rs_busy), .rt_busy(rt_busy),
      .id_hold(id_hold), .cmp_result(cmp_result), .cnt_clr(cnt_clr),
      .cmp_op(cmp_op), .br_stall(br_stall), .br_ack(br_ack),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .illegal_op(illegal_op), .branch_cnt(branch_cnt),
      .taken_cnt(taken_cnt), .stall_cnt(stall_cnt)
   );

   branch_ctrl #(.CNT_W(2)) dut_s (
      .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_type(br_type),
      .br_target(br_target), .rs_busy(rs_busy), .rt_busy(rt_busy),
      .id_hold(id_hold), .cmp_result(cmp_result), .cnt_clr(cnt_clr),
      .cmp_op(cmp_op_s), .br_stall(br_stall_s), .br_ack(br_ack_s),
      .redirect_valid(redirect_valid_s), .redirect_pc(redirect_pc_s),
      .illegal_op(illegal_op_s), .branch_cnt(branch_cnt_s),
      .taken_cnt(taken_cnt_s), .stall_cnt(stall_cnt_s)
   );

   always #5 clk = ~clk;

   // Reference model built from the instruction-level rules.
   function automatic bit f_uses_rt(input logic [2:0] t);
      return (t == 3'd0) || (t == 3'd1);
   endfunction

   function automatic bit f_legal(input logic [2:0] t);
      return t <= 3'd5;
   endfunction

   function automatic bit f_hazard(input logic [2:0] t, input logic rs, input logic rt);
      return rs || (rt && f_uses_rt(t));
   endfunction

   wire m_stall   = br_valid && f_hazard(br_type, rs_busy, rt_busy);
   wire m_resolve = br_valid && !f_hazard(br_type, rs_busy, rt_busy) && !id_hold;
   wire m_taken   = m_resolve && f_legal(br_type) && cmp_result;
   wire [2:0] m_cmp_op = br_valid ? br_type : 3'd0;

   logic        m_rv, m_ill;
   logic [31:0] m_rpc;
   int m_bc, m_tc, m_sc, m_bc2, m_tc2, m_sc2;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_rv <= 1'b0; m_rpc <= 32'd0; m_ill <= 1'b0;
         m_bc <= 0; m_tc <= 0; m_sc <= 0; m_bc2 <= 0; m_tc2 <= 0; m_sc2 <= 0;
      end else begin
         m_rv <= m_taken;
         if (m_taken) m_rpc <= br_target;
         if (m_resolve && !f_legal(br_type)) m_ill <= 1'b1;
         if (cnt_clr) begin
            m_bc <= 0; m_tc <= 0; m_sc <= 0; m_bc2 <= 0; m_tc2 <= 0; m_sc2 <= 0;
         end else begin
            if (m_resolve) begin
               m_bc  <= (m_bc  < 65535) ? m_bc  + 1 : m_bc;
               m_bc2 <= (m_bc2 < 3)     ? m_bc2 + 1 : m_bc2;
            end
            if (m_taken) begin
               m_tc  <= (m_tc  < 65535) ? m_tc  + 1 : m_tc;
               m_tc2 <= (m_tc2 < 3)     ? m_tc2 + 1 : m_tc2;
            end
            if (m_stall && !id_hold) begin
               m_sc  <= (m_sc  < 65535) ? m_sc  + 1 : m_sc;
               m_sc2 <= (m_sc2 < 3)     ? m_sc2 + 1 : m_sc2;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      br_valid = 0; br_type = 3'd0; br_target = 32'd0; rs_busy = 0; rt_busy = 0;
      id_hold = 0; cmp_result = 0; cnt_clr = 0;
   endtask

   task automatic clear_counters();
      idle_inputs();
      cnt_clr = 1;
      tick();
      cnt_clr = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 0;
      #12;
      checks++;
      if (redirect_valid !== 1'b0 || redirect_pc !== 32'd0 || illegal_op !== 1'b0) begin
         errors++;
         $display("FAIL reset_regs: rv=%b pc=%h ill=%b required 0/0/0", redirect_valid, redirect_pc, illegal_op);
      end
      checks++;
      if (branch_cnt !== 16'd0 || taken_cnt !== 16'd0 || stall_cnt !== 16'd0) begin
         errors++;
         $display("FAIL reset_cnt: %0d/%0d/%0d required 0/0/0", branch_cnt, taken_cnt, stall_cnt);
      end
      br_valid = 1; br_type = 3'd2; rs_busy = 1;
      #1;
      checks++;
      if (cmp_op !== 3'd2 || br_stall !== 1'b1 || br_ack !== 1'b0) begin
         errors++;
         $display("FAIL reset_comb: op=%0d stall=%b ack=%b required 2/1/0", cmp_op, br_stall, br_ack);
      end
      idle_inputs();
      @(negedge clk);
      rst_n = 1;
      tick();
   endtask

   task automatic test_beq_taken();
      clear_counters();
      br_valid = 1; br_type = 3'd0; cmp_result = 1; br_target = 32'h0040_0020;
      #1;
      checks++;
      if (br_ack !== 1'b1 || redirect_valid !== 1'b0 || cmp_op !== 3'd0) begin
         errors++;
         $display("FAIL beq_T: ack=%b rv=%b required 1/0", br_ack, redirect_valid);
      end
      tick();
      idle_inputs();
      #1;
      checks++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0040_0020) begin
         errors++;
         $display("FAIL beq_T1: rv=%b pc=%h required 1/00400020", redirect_valid, redirect_pc);
      end
      checks++;
      if (branch_cnt !== 16'd1 || taken_cnt !== 16'd1) begin
         errors++;
         $display("FAIL beq_cnt: %0d/%0d required 1/1", branch_cnt, taken_cnt);
      end
      tick();
      checks++;
      if (redirect_valid !== 1'b0 || redirect_pc !== 32'h0040_0020) begin
         errors++;
         $display("FAIL beq_T2: rv=%b pc=%h required 0/00400020", redirect_valid, redirect_pc);
      end
   endtask

   task automatic test_bne_not_taken();
      clear_counters();
      br_valid = 1; br_type = 3'd1; cmp_result = 0; br_target = 32'h0000_1234;
      #1;
      checks++;
      if (br_ack !== 1'b1) begin
         errors++;
         $display("FAIL bne_ack: %b required 1", br_ack);
      end
      tick();
      idle_inputs();
      #1;
      checks++;
      if (redirect_valid !== 1'b0 || branch_cnt !== 16'd1 || taken_cnt !== 16'd0) begin
         errors++;
         $display("FAIL bne_result: rv=%b bc=%0d tc=%0d required 0/1/0", redirect_valid, branch_cnt, taken_cnt);
      end
   endtask

   task automatic test_stall();
      clear_counters();
      br_valid = 1; br_type = 3'd3; rt_busy = 1; cmp_result = 0;
      #1;
      checks++;
      if (br_stall !== 1'b0 || br_ack !== 1'b1) begin
         errors++;
         $display("FAIL bgtz_rt_ignored: stall=%b ack=%b required 0/1", br_stall, br_ack);
      end
      tick();
      br_type = 3'd0; cmp_result = 1; br_target = 32'h0000_8000;
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++;
         if (br_stall !== 1'b1 || br_ack !== 1'b0) begin
            errors++;
            $display("FAIL beq_stall%0d: stall=%b ack=%b required 1/0", i, br_stall, br_ack);
         end
         tick();
      end
      rt_busy = 0;
      #1;
      checks++;
      if (br_stall !== 1'b0 || br_ack !== 1'b1) begin
         errors++;
         $display("FAIL beq_release: stall=%b ack=%b required 0/1", br_stall, br_ack);
      end
      tick();
      idle_inputs();
      #1;
      checks++;
      if (stall_cnt !== 16'd2 || branch_cnt !== 16'd2 || redirect_valid !== 1'b1 || redirect_pc !== 32'h0000_8000) begin
         errors++;
         $display("FAIL stall_result: sc=%0d bc=%0d rv=%b pc=%h required 2/2/1/00008000", stall_cnt, branch_cnt, redirect_valid, redirect_pc);
      end
   endtask

   task automatic test_hold();
      clear_counters();
      br_valid = 1; br_type = 3'd0; rt_busy = 1; cmp_result = 1; br_target = 32'h0000_4444;
      tick();
      id_hold = 1;
      tick();
      rt_busy = 0;
      #1;
      checks++;
      if (br_stall !== 1'b0 || br_ack !== 1'b0) begin
         errors++;
         $display("FAIL hold_no_resolve: stall=%b ack=%b required 0/0", br_stall, br_ack);
      end
      tick();
      checks++;
      if (redirect_valid !== 1'b0) begin
         errors++;
         $display("FAIL hold_no_redirect: rv=%b required 0", redirect_valid);
      end
      id_hold = 0;
      #1;
      checks++;
      if (br_ack !== 1'b1) begin
         errors++;
         $display("FAIL hold_release_ack: %b required 1", br_ack);
      end
      tick();
      idle_inputs();
      #1;
      checks++;
      if (stall_cnt !== 16'd1 || branch_cnt !== 16'd1 || redirect_valid !== 1'b1) begin
         errors++;
         $display("FAIL hold_result: sc=%0d bc=%0d rv=%b required 1/1/1", stall_cnt, branch_cnt, redirect_valid);
      end
   endtask

   task automatic test_back_to_back();
      idle_inputs();
      br_valid = 1; br_type = 3'd4; cmp_result = 1; br_target = 32'h0000_0100;
      tick();
      br_type = 3'd5; br_target = 32'h0000_0200;
      #1;
      checks++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0000_0100 || br_ack !== 1'b1) begin
         errors++;
         $display("FAIL slot_T1: rv=%b pc=%h ack=%b required 1/00000100/1", redirect_valid, redirect_pc, br_ack);
      end
      tick();
      idle_inputs();
      #1;
      checks++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0000_0200) begin
         errors++;
         $display("FAIL slot_T2: rv=%b pc=%h required 1/00000200", redirect_valid, redirect_pc);
      end
   endtask

   task automatic test_illegal();
      idle_inputs();
      br_valid = 1; br_type = 3'd7; cmp_result = 1; br_target = 32'hDEAD_0000;
      tick();
      idle_inputs();
      #1;
      checks++;
      if (illegal_op !== 1'b1 || redirect_valid !== 1'b0) begin
         errors++;
         $display("FAIL illegal_set: ill=%b rv=%b required 1/0", illegal_op, redirect_valid);
      end
      for (int i = 0; i < 3; i++) begin
         br_valid = 1; br_type = 3'(i); cmp_result = 1'(i);
         tick();
      end
      idle_inputs();
      #1;
      checks++;
      if (illegal_op !== 1'b1) begin
         errors++;
         $display("FAIL illegal_sticky: ill=%b required 1", illegal_op);
      end
   endtask

   task automatic test_reset_midflight();
      idle_inputs();
      br_valid = 1; br_type = 3'd0; cmp_result = 1; br_target = 32'h0000_0ABC;
      tick();
      rs_busy = 1;
      #1;
      rst_n = 0;
      #1;
      checks++;
      if (redirect_valid !== 1'b0 || illegal_op !== 1'b0 || branch_cnt !== 16'd0 || redirect_pc !== 32'd0) begin
         errors++;
         $display("FAIL reset_pending: rv=%b ill=%b bc=%0d pc=%h required 0/0/0/0", redirect_valid, illegal_op, branch_cnt, redirect_pc);
      end
      @(negedge clk);
      rst_n = 1;
      tick();
      tick();
      #1;
      rst_n = 0;
      #1;
      checks++;
      if (redirect_valid !== 1'b0 || stall_cnt !== 16'd0 || br_stall !== 1'b1) begin
         errors++;
         $display("FAIL reset_wait: rv=%b sc=%0d stall=%b required 0/0/1", redirect_valid, stall_cnt, br_stall);
      end
      idle_inputs();
      @(negedge clk);
      rst_n = 1;
      tick();
      checks++;
      if (redirect_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: rv=%b required 0", redirect_valid);
      end
   endtask

   task automatic test_saturation();
      clear_counters();
      br_valid = 1; br_type = 3'd0; cmp_result = 1; br_target = 32'h0000_0040;
      for (int i = 0; i < 5; i++) tick();
      #1;
      checks++;
      if (taken_cnt_s !== 2'd3 || branch_cnt_s !== 2'd3 || taken_cnt !== 16'd5) begin
         errors++;
         $display("FAIL saturate: tc2=%0d bc2=%0d tc16=%0d required 3/3/5", taken_cnt_s, branch_cnt_s, taken_cnt);
      end
      cnt_clr = 1;
      tick();
      idle_inputs();
      #1;
      checks++;
      if (taken_cnt_s !== 2'd0 || taken_cnt !== 16'd0 || branch_cnt !== 16'd0) begin
         errors++;
         $display("FAIL clr_priority: tc2=%0d tc16=%0d bc16=%0d required 0/0/0", taken_cnt_s, taken_cnt, branch_cnt);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         br_valid   = 1'($urandom_range(0, 3) != 0);
         br_type    = 3'($urandom_range(0, 7));
         br_target  = $urandom;
         rs_busy    = 1'($urandom_range(0, 3) == 0);
         rt_busy    = 1'($urandom_range(0, 2) == 0);
         id_hold    = 1'($urandom_range(0, 4) == 0);
         cmp_result = 1'($urandom);
         cnt_clr    = 1'($urandom_range(0, 40) == 0);
         #1;
         checks++;
         if (cmp_op !== m_cmp_op || br_stall !== m_stall || br_ack !== m_resolve) begin
            errors++;
            $display("FAIL rnd_comb[%0d]: op=%0d stall=%b ack=%b required %0d/%b/%b", n, cmp_op, br_stall, br_ack, m_cmp_op, m_stall, m_resolve);
         end
         checks++;
         if (redirect_valid !== m_rv || (m_rv && redirect_pc !== m_rpc) || illegal_op !== m_ill) begin
            errors++;
            $display("FAIL rnd_regs[%0d]: rv=%b pc=%h ill=%b required %b/%h/%b", n, redirect_valid, redirect_pc, illegal_op, m_rv, m_rpc, m_ill);
         end
         checks++;
         if (branch_cnt !== 16'(m_bc) || taken_cnt !== 16'(m_tc) || stall_cnt !== 16'(m_sc) ||
             branch_cnt_s !== 2'(m_bc2) || taken_cnt_s !== 2'(m_tc2) || stall_cnt_s !== 2'(m_sc2)) begin
            errors++;
            $display("FAIL rnd_cnt[%0d]: %0d/%0d/%0d %0d/%0d/%0d required %0d/%0d/%0d %0d/%0d/%0d", n,
                     branch_cnt, taken_cnt, stall_cnt, branch_cnt_s, taken_cnt_s, stall_cnt_s,
                     m_bc, m_tc, m_sc, m_bc2, m_tc2, m_sc2);
         end
         tick();
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_beq_taken();
      test_bne_not_taken();
      test_stall();
      test_hold();
      test_back_to_back();
      test_illegal();
      test_reset_midflight();
      test_saturation();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
